// File: rtl/spiphy_burst.sv
// spiphy_burst: SPI master PHY that runs one frame per start request.
// It can keep chip select asserted between frames, so that back-to-back bursts
// to the same device skip the setup phase.
//
// Ports:
//   spi_clock_i / spi_resetn_i   single clock (rising edge); async active-low reset
//   spi_start_i                  single-cycle frame request (IDLE or HELD only)
//   spi_len_i                    frame length minus one, in bits
//   spi_csid_i                   target chip select
//   spi_cs_hold_i                keep CS low after this frame
//   spi_release_i                drop a held CS (start wins if both are seen)
//   spi_lsb_first_i              bit order
//   spi_tx_data_i                transmit word, right-justified
//   spi_clkdiv_i                 SCK half-period minus one, in clock cycles
//   cpol, cpha                   SPI mode
//   spi_done_o / spi_busy_o      frame-complete pulse / frame in progress
//   spi_rx_o                     received word, right-justified, zero-extended
//   miso[NCS], mosi, sck, cs_n[NCS]  SPI pins
module spiphy_burst #(
   parameter int DATAW = 32,
   parameter int NCS   = 4,
   parameter int DIVW  = 10
) (
   input  logic                     spi_clock_i,
   input  logic                     spi_resetn_i,
   input  logic                     spi_start_i,
   input  logic [$clog2(DATAW)-1:0] spi_len_i,
   input  logic [$clog2(NCS)-1:0]   spi_csid_i,
   input  logic                     spi_cs_hold_i,
   input  logic                     spi_release_i,
   input  logic                     spi_lsb_first_i,
   input  logic [DATAW-1:0]         spi_tx_data_i,
   input  logic [DIVW-1:0]          spi_clkdiv_i,
   input  logic                     cpol,
   input  logic                     cpha,
   output logic                     spi_done_o,
   output logic                     spi_busy_o,
   output logic [DATAW-1:0]         spi_rx_o,
   input  logic [NCS-1:0]           miso,
   output logic                     mosi,
   output logic                     sck,
   output logic [NCS-1:0]           cs_n
);
   localparam int LENW = $clog2(DATAW);
   localparam int CSW  = $clog2(NCS);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, TAIL, HELD, SWITCH} state_t;

   state_t            state_q, state_d;
   logic [LENW-1:0]   len_q, len_d, idx_q, idx_d;
   logic [CSW-1:0]    csid_q, csid_d;
   logic              hold_q, hold_d, lsb_q, lsb_d, cpha_q, cpha_d;
   logic [DATAW-1:0]  tx_q, tx_d, sh_q, sh_d, rx_q, rx_d;
   logic [DIVW-1:0]   div_q, div_d, cnt_q, cnt_d;
   logic [LENW:0]     edge_q, edge_d;   // index of the next SCK edge in the frame
   logic              sck_q, sck_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
   logic [NCS-1:0]    cs_n_q, cs_n_d;

   logic              accept, half_end, last_edge, lead_edge, do_sample, do_update;
   logic [LENW-1:0]   rx_pos;

   assign accept    = spi_start_i && (state_q == IDLE || state_q == HELD);
   assign half_end  = (cnt_q == div_q);
   assign last_edge = (edge_q == {len_q, 1'b1});
   assign lead_edge = ~edge_q[0];
   // Both modes carry bit j across edges 2j and 2j+1, so the RX slot is edge/2.
   assign rx_pos    = edge_q[LENW:1];
   assign do_sample = cpha_q ? ~lead_edge : lead_edge;
   // cpha=1: the first bit is already on mosi from setup/entry, so the first
   // leading edge does not advance; cpha=0: nothing to advance after the last edge.
   assign do_update = cpha_q ? (lead_edge && (edge_q != '0)) : (~lead_edge && !last_edge);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      csid_d  = csid_q;
      hold_d  = hold_q;
      lsb_d   = lsb_q;
      cpha_d  = cpha_q;
      tx_d    = tx_q;
      sh_d    = sh_q;
      rx_d    = rx_q;
      div_d   = div_q;
      edge_d  = edge_q;
      sck_d   = sck_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cnt_d   = half_end ? '0 : cnt_q + 1'b1;

      case (state_q)
         IDLE, HELD: begin
            cnt_d = '0;
            if (accept) begin
               len_d  = spi_len_i;
               csid_d = spi_csid_i;
               hold_d = spi_cs_hold_i;
               lsb_d  = spi_lsb_first_i;
               cpha_d = cpha;
               tx_d   = spi_tx_data_i;
               div_d  = spi_clkdiv_i;
               idx_d  = spi_lsb_first_i ? '0 : spi_len_i;
               edge_d = '0;
               sh_d   = '0;
               sck_d  = cpol;
               busy_d = 1'b1;
               if (state_q == IDLE)
                  state_d = SETUP;
               else if (spi_csid_i == csid_q)
                  state_d = SHIFT;
               else
                  state_d = SWITCH;
            end else if (state_q == HELD && spi_release_i) begin
               state_d = IDLE;
            end
         end
         SWITCH: if (half_end) state_d = SETUP;
         SETUP:  if (half_end) state_d = SHIFT;
         SHIFT: begin
            if (half_end) begin
               sck_d = ~sck_q;
               if (do_sample) begin
                  if (lsb_q) sh_d[rx_pos] = miso[csid_q];
                  else       sh_d = {sh_q[DATAW-2:0], miso[csid_q]};
               end
               if (do_update) idx_d = lsb_q ? idx_q + 1'b1 : idx_q - 1'b1;
               if (last_edge) state_d = TAIL;
               else           edge_d  = edge_q + 1'b1;
            end
         end
         TAIL: begin
            if (half_end) begin
               rx_d    = sh_q;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = hold_q ? HELD : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // mosi keeps the last bit through TAIL so a trailing-edge sampler has hold time.
      mosi_d = (state_d == SETUP || state_d == SHIFT || state_d == TAIL) ? tx_d[idx_d] : 1'b0;
      cs_n_d = (state_d == SETUP || state_d == SHIFT || state_d == TAIL || state_d == HELD)
               ? ~({{(NCS-1){1'b0}}, 1'b1} << csid_d) : '1;
   end

   always_ff @(posedge spi_clock_i or negedge spi_resetn_i) begin
      if (!spi_resetn_i) begin
         state_q <= IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         csid_q  <= '0;
         hold_q  <= 1'b0;
         lsb_q   <= 1'b0;
         cpha_q  <= 1'b0;
         tx_q    <= '0;
         sh_q    <= '0;
         rx_q    <= '0;
         div_q   <= '0;
         cnt_q   <= '0;
         edge_q  <= '0;
         sck_q   <= 1'b0;
         mosi_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cs_n_q  <= '1;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         csid_q  <= csid_d;
         hold_q  <= hold_d;
         lsb_q   <= lsb_d;
         cpha_q  <= cpha_d;
         tx_q    <= tx_d;
         sh_q    <= sh_d;
         rx_q    <= rx_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         edge_q  <= edge_d;
         sck_q   <= sck_d;
         mosi_q  <= mosi_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cs_n_q  <= cs_n_d;
      end
   end

   // Idle SCK follows the live cpol input, including while reset is held.
   assign sck        = (state_q == IDLE) ? cpol : sck_q;
   assign mosi       = mosi_q;
   assign cs_n       = cs_n_q;
   assign spi_busy_o = busy_q;
   assign spi_done_o = done_q;
   assign spi_rx_o   = rx_q;
endmodule

// File: tb/tb_spiphy_burst.sv
// Bench for spiphy_burst: directed mode/hold/switch/reset scenarios plus random
// frames, checked against a timing and bit-order model of the SPI protocol.
module tb_spiphy_burst;
   localparam int DATAW = 32;
   localparam int NCS   = 4;
   localparam int DIVW  = 10;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start, hold, rel, lsb, cpol_i, cpha_i, miso_one;
   logic [4:0]        len;
   logic [1:0]        csid;
   logic [DATAW-1:0]  tx;
   logic [DIVW-1:0]   div;
   logic              done, busy, mosi, sck;
   logic [DATAW-1:0]  rx;
   logic [NCS-1:0]    miso, cs_n;

   int checks = 0;
   int errors = 0;
   bit m_held = 1'b0;
   int m_csid = 0;

   always #5 clk = ~clk;

   // Slave model: either loop mosi back on every miso line or tie them high.
   assign miso = miso_one ? {NCS{1'b1}} : {NCS{mosi}};

   spiphy_burst #(.DATAW(DATAW), .NCS(NCS), .DIVW(DIVW)) dut (
      .spi_clock_i(clk), .spi_resetn_i(rst_n), .spi_start_i(start),
      .spi_len_i(len), .spi_csid_i(csid), .spi_cs_hold_i(hold),
      .spi_release_i(rel), .spi_lsb_first_i(lsb), .spi_tx_data_i(tx),
      .spi_clkdiv_i(div), .cpol(cpol_i), .cpha(cpha_i),
      .spi_done_o(done), .spi_busy_o(busy), .spi_rx_o(rx),
      .miso(miso), .mosi(mosi), .sck(sck), .cs_n(cs_n)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Runs one frame starting at the current negedge and checks it against the
   // protocol model: phase durations in half-periods, edge count and spacing,
   // bit order on mosi, received word, CS behaviour, done/busy and rx stability.
   task automatic frame(input string nm, input int c_id, input int ln, input bit lsb_f,
                        input logic [31:0] txw, input int dv, input bit cp, input bit ph,
                        input bit hld, input bit one, input bit rl, input int glitch_k);
      int h, pre, first_k, lat, sw, n_edges, last_k, first_seen, spacing_bad;
      int done_cnt, done_k, cs_bad, oh_bad, rx_bad, busy_bad, e;
      logic [31:0] seq, mask, exp_seq, exp_rx, rx_prev;
      logic [NCS-1:0] cs_sel;
      logic sck_prev;
      h       = dv + 1;
      // half-periods spent before SHIFT: IDLE->SETUP 1, HELD same CS 0, HELD other CS 2
      pre     = !m_held ? 1 : ((c_id == m_csid) ? 0 : 2);
      sw      = (pre == 2) ? h : 0;
      first_k = (pre + 1) * h;
      lat     = (pre + 2 * (ln + 1) + 1) * h;
      mask    = 32'((64'd1 << (ln + 1)) - 64'd1);
      exp_seq = '0;
      for (int j = 0; j <= ln; j++) exp_seq[j] = lsb_f ? txw[j] : txw[ln - j];
      exp_rx  = one ? mask : (txw & mask);
      cs_sel  = ~(4'b0001 << c_id);

      csid = c_id[1:0]; len = ln[4:0]; lsb = lsb_f; tx = txw; div = dv[DIVW-1:0];
      cpol_i = cp; cpha_i = ph; hold = hld; miso_one = one; rel = rl; start = 1'b1;
      @(negedge clk);
      start = 1'b0; rel = 1'b0;
      check({nm, "_mosi_first"}, 64'(mosi), 64'(exp_seq[0]));
      seq = '0; n_edges = 0; last_k = 0; first_seen = -1; spacing_bad = 0;
      done_cnt = 0; done_k = -1; cs_bad = 0; oh_bad = 0; rx_bad = 0; busy_bad = 0;
      rx_prev = rx; sck_prev = sck;
      for (int k = 0; k <= lat + 2; k++) begin
         if (sck !== sck_prev) begin
            e = n_edges;
            if (e == 0) first_seen = k;
            else if (k - last_k != h) spacing_bad++;
            if (((ph && e[0]) || (!ph && !e[0])) && (e >> 1) < 32) seq[e >> 1] = mosi;
            n_edges++;
            last_k = k;
            sck_prev = sck;
         end
         if (done) begin done_cnt++; done_k = k; end
         if (busy !== (k < lat)) busy_bad++;
         if (k < lat) begin
            if (k < sw) begin if (cs_n !== 4'hF) cs_bad++; end
            else if (cs_n !== cs_sel) cs_bad++;
         end
         if ($countones(~cs_n) > 1) oh_bad++;
         if (k != lat && rx !== rx_prev) rx_bad++;
         rx_prev = rx;
         if (k == glitch_k) begin
            start = 1'b1; tx = $urandom; csid = 2'($urandom_range(0, 3));
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check({nm, "_edges"},      64'(n_edges),     64'(2 * (ln + 1)));
      check({nm, "_first_edge"}, 64'(first_seen),  64'(first_k));
      check({nm, "_spacing"},    64'(spacing_bad), 64'd0);
      check({nm, "_done_cnt"},   64'(done_cnt),    64'd1);
      check({nm, "_done_cyc"},   64'(done_k),      64'(lat));
      check({nm, "_mosi_seq"},   64'(seq & mask),  64'(exp_seq));
      check({nm, "_rx"},         64'(rx),          64'(exp_rx));
      check({nm, "_busy"},       64'(busy_bad),    64'd0);
      check({nm, "_cs"},         64'(cs_bad),      64'd0);
      check({nm, "_cs_onehot"},  64'(oh_bad),      64'd0);
      check({nm, "_rx_stable"},  64'(rx_bad),      64'd0);
      check({nm, "_cs_after"},   64'(cs_n),        64'(hld ? cs_sel : 4'hF));
      m_held = hld;
      m_csid = c_id;
   endtask

   task automatic release_cs(input string nm);
      rel = 1'b1;
      @(negedge clk);
      rel = 1'b0;
      @(negedge clk);
      check({nm, "_release_cs"}, 64'(cs_n), 64'hF);
      m_held = 1'b0;
   endtask

   initial begin
      int n, c, ln, dv;
      logic prev;
      rst_n = 1'b0; start = 0; hold = 0; rel = 0; lsb = 0; cpol_i = 0; cpha_i = 0;
      miso_one = 0; len = '0; csid = '0; tx = '0; div = '0;
      #12;
      check("rst_cs_n", 64'(cs_n), 64'hF);
      check("rst_sck",  64'(sck),  64'd0);
      check("rst_mosi", 64'(mosi), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_rx",   64'(rx),   64'd0);
      cpol_i = 1'b1; #1;
      check("rst_sck_live_cpol", 64'(sck), 64'd1);
      cpol_i = 1'b0;
      @(negedge clk); rst_n = 1'b1; @(negedge clk);

      // mode 0, H=2, 8 bits MSB-first, loopback
      frame("m0_a5", 0, 7, 1'b0, 32'hA5, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      // mode 3, LSB-first, 4 bits, miso high
      frame("m3_lsb", 1, 3, 1'b1, 32'h9, 2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1);
      // start pulsed mid-frame must be ignored
      frame("busy_start", 0, 15, 1'b0, $urandom, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20);
      // held CS on the same device; second start also raises release (start wins)
      frame("hold_a", 2, 7, 1'b0, $urandom, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
      frame("hold_b", 2, 9, 1'b1, $urandom, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      // held on CS1, then switch to CS3
      frame("sw_a", 1, 5, 1'b0, $urandom, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
      frame("sw_b", 3, 5, 1'b1, $urandom, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
      release_cs("sw");

      for (int i = 0; i < 8; i++) begin
         c  = $urandom_range(0, 3);
         ln = $urandom_range(0, 31);
         dv = $urandom_range(0, 3);
         frame($sformatf("rnd%0d", i), c, ln, 1'($urandom_range(0, 1)), $urandom, dv,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, -1);
      end
      if (m_held) release_cs("rnd");

      // reset in the middle of a 32-bit frame (rx is nonzero from earlier frames)
      frame("pre_rst", 1, 7, 1'b0, 32'h3C, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      csid = 2'd1; len = 5'd31; lsb = 0; tx = $urandom; div = 10'd1;
      cpol_i = 0; cpha_i = 0; hold = 0; miso_one = 0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0; prev = sck;
      for (int k = 0; k < 200 && n < 5; k++) begin
         @(negedge clk);
         if (sck !== prev) n++;
         prev = sck;
      end
      check("rst_mid_edges_seen", 64'(n), 64'd5);
      #2 rst_n = 1'b0; #1;
      check("mid_rst_cs_n", 64'(cs_n), 64'hF);
      check("mid_rst_sck",  64'(sck),  64'd0);
      check("mid_rst_mosi", 64'(mosi), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_done", 64'(done), 64'd0);
      check("mid_rst_rx",   64'(rx),   64'd0);
      @(negedge clk); rst_n = 1'b1; m_held = 1'b0;
      @(negedge clk);
      frame("post_rst", 2, 31, 1'b0, $urandom, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
